// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD panel IDs, strap pin map and ID-reader FSM types
// Purpose: constants shared by lcd_id_reader, clk_div and lcd_driver, plus the
//          strap-code decode and a counter-width helper.
package lcd_pkg;

  // Panel IDs consumed by the pixel-clock divider and timing generator
  localparam logic [15:0] LCD_ID_4342 = 16'h4342;
  localparam logic [15:0] LCD_ID_7084 = 16'h7084;
  localparam logic [15:0] LCD_ID_7016 = 16'h7016;
  localparam logic [15:0] LCD_ID_4384 = 16'h4384;
  localparam logic [15:0] LCD_ID_1018 = 16'h1018;

  // Strap pins inside the {R[7:0],G[7:0],B[7:0]} bus
  localparam int M0_BIT = 23;
  localparam int M1_BIT = 15;
  localparam int M2_BIT = 7;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_SAMPLE,
    ST_DECODE,
    ST_DONE,
    ST_ERROR
  } id_state_t;

  typedef struct packed {
    logic        ok;
    logic [15:0] id;
  } id_decode_t;

  // Counter width for a count range of n, never below one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // code = {M2,M1,M0}; unsupported codes return ok=0 and a zero ID
  function automatic id_decode_t decode_strap(input logic [2:0] code);
    id_decode_t d;
    d.ok = 1'b1;
    case (code)
      3'b000:  d.id = LCD_ID_4342;
      3'b001:  d.id = LCD_ID_7084;
      3'b010:  d.id = LCD_ID_7016;
      3'b100:  d.id = LCD_ID_4384;
      3'b101:  d.id = LCD_ID_1018;
      default: begin
        d.ok = 1'b0;
        d.id = 16'h0000;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lcd_id_reader_if.sv
// rtl/lcd_id_reader_if.sv - pin/ID bundle between LCD pads, ID reader and consumers
// Purpose: groups rescan, the RGB input path and the decoded-ID outputs.
// Signals: rescan (restart pulse), lcd_rgb_in[23:0] (pad input path),
//          lcd_rgb_oe (pad output enable), lcd_id[15:0], id_valid, id_err.
// Modports: master = board/controller side, slave = lcd_id_reader.
interface lcd_id_reader_if;
  logic        rescan;
  logic [23:0] lcd_rgb_in;
  logic        lcd_rgb_oe;
  logic [15:0] lcd_id;
  logic        id_valid;
  logic        id_err;

  modport master (
    output rescan, lcd_rgb_in,
    input  lcd_rgb_oe, lcd_id, id_valid, id_err
  );

  modport slave (
    input  rescan, lcd_rgb_in,
    output lcd_rgb_oe, lcd_id, id_valid, id_err
  );
endinterface

// File: rtl/lcd_strap_debounce.sv
// rtl/lcd_strap_debounce.sv - strap-code synchronizer, stability filter and timeout
// Purpose: synchronizes the 3-bit strap code and accepts it once it has been
//          seen STABLE_CNT consecutive cycles while enabled.
// Ports: clk, rst (sync, active-high), clear (restart), enable (SAMPLE phase),
//        code_in[2:0] (asynchronous pins), accepted_code[2:0], accept, timeout.
module lcd_strap_debounce
  import lcd_pkg::*;
#(
  parameter int STABLE_CNT  = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [2:0] code_in,
  output logic [2:0] accepted_code,
  output logic       accept,
  output logic       timeout
);

  // The stable counter must be able to hold STABLE_CNT itself
  localparam int STABLE_W  = cnt_w(STABLE_CNT + 1);
  localparam int TIMEOUT_W = cnt_w(TIMEOUT_CYC);
  localparam logic [STABLE_W-1:0]  STABLE_MAX   = STABLE_W'(STABLE_CNT);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [2:0]           sync1;
  logic [2:0]           sync2;
  logic [2:0]           held;
  logic [STABLE_W-1:0]  stable_cnt;
  logic [TIMEOUT_W-1:0] timeout_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= code_in;
      sync2 <= sync1;
    end
  end

  // Acceptance takes priority over a timeout landing in the same cycle
  assign accept  = enable && (stable_cnt == STABLE_MAX);
  assign timeout = enable && !accept && (timeout_cnt == TIMEOUT_LAST);
  assign accepted_code = held;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      held        <= '0;
      stable_cnt  <= '0;
      timeout_cnt <= '0;
    end else if (!enable) begin
      // held survives leaving SAMPLE so the decode sees the accepted code
      stable_cnt  <= '0;
      timeout_cnt <= '0;
    end else if (!accept) begin
      // Sampling freezes on acceptance so held cannot change under the decode
      if (timeout_cnt != TIMEOUT_LAST) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
      if (sync2 == held) begin
        if (stable_cnt != STABLE_MAX) begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        held       <= sync2;
        stable_cnt <= STABLE_W'(1);
      end
    end
  end

endmodule

// File: rtl/lcd_id_reader.sv
// rtl/lcd_id_reader.sv - reads the LCD panel strap code and publishes the panel ID
// Purpose: keeps the RGB bus released after reset, debounces the M2/M1/M0
//          straps, decodes them to lcd_id and then hands the bus to the driver.
// Ports: clk, rst (sync, active-high), bus (lcd_id_reader_if.slave):
//        rescan, lcd_rgb_in in; lcd_rgb_oe, lcd_id, id_valid, id_err out.
module lcd_id_reader
  import lcd_pkg::*;
#(
  parameter int SETTLE_CYC  = 50000,
  parameter int STABLE_CNT  = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  lcd_id_reader_if.slave bus
);

  localparam int SETTLE_W = cnt_w(SETTLE_CYC);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

  id_state_t          state;
  id_state_t          state_next;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [2:0]         strap_code;
  logic [2:0]         accepted_code;
  logic               accept;
  logic               timeout;
  id_decode_t         decoded;

  logic               oe_next;
  logic               valid_next;
  logic               err_next;
  logic [15:0]        id_next;
  logic               oe_q;
  logic               valid_q;
  logic               err_q;
  logic [15:0]        id_q;
  logic               unused_bus_bits;

  assign strap_code = {bus.lcd_rgb_in[M2_BIT], bus.lcd_rgb_in[M1_BIT], bus.lcd_rgb_in[M0_BIT]};
  assign unused_bus_bits = ^{bus.lcd_rgb_in[22:16], bus.lcd_rgb_in[14:8], bus.lcd_rgb_in[6:0]};

  lcd_strap_debounce #(
    .STABLE_CNT  (STABLE_CNT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_debounce (
    .clk           (clk),
    .rst           (rst),
    .clear         (bus.rescan),
    .enable        (state == ST_SAMPLE),
    .code_in       (strap_code),
    .accepted_code (accepted_code),
    .accept        (accept),
    .timeout       (timeout)
  );

  assign decoded = decode_strap(accepted_code);

  // State register and settle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
    end else begin
      state <= state_next;
      if (bus.rescan || (state != ST_SETTLE) || (settle_cnt == SETTLE_LAST)) begin
        settle_cnt <= '0;
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  // Next-state logic; rescan overrides every state
  always_comb begin
    state_next = state;
    if (bus.rescan) begin
      state_next = ST_SETTLE;
    end else begin
      case (state)
        ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = ST_SAMPLE;
        ST_SAMPLE: begin
          if (accept)       state_next = ST_DECODE;
          else if (timeout) state_next = ST_ERROR;
        end
        ST_DECODE: state_next = decoded.ok ? ST_DONE : ST_ERROR;
        ST_DONE:   state_next = ST_DONE;
        ST_ERROR:  state_next = ST_ERROR;
        default:   state_next = ST_SETTLE;
      endcase
    end
  end

  // Outputs follow the state being entered so they are valid in its first cycle
  always_comb begin
    oe_next    = 1'b0;
    valid_next = 1'b0;
    err_next   = 1'b0;
    id_next    = 16'h0000;
    case (state_next)
      ST_DONE: begin
        oe_next    = 1'b1;
        valid_next = 1'b1;
        id_next    = (state == ST_DECODE) ? decoded.id : id_q;
      end
      ST_ERROR: err_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= 16'h0000;
    end else begin
      oe_q    <= oe_next;
      valid_q <= valid_next;
      err_q   <= err_next;
      id_q    <= id_next;
    end
  end

  assign bus.lcd_rgb_oe = oe_q;
  assign bus.id_valid   = valid_q;
  assign bus.id_err     = err_q;
  assign bus.lcd_id     = id_q;

endmodule
